alu_issue_ctrl: RTL and testbench
=================================

// Module: alu_issue_ctrl
// PURPOSE
//  Upstream issue stage for the 4-op registered ALU (add, sub, add-with-c+carry, xor).
//  - Buffers operation commands in a valid/ready FIFO and drives the ALU operand/select inputs from registers.
//  - Tracks the ALU's one-cycle registered latency and captures each ALU result into an ordered result FIFO.
//  - Supports result chaining: the previous result becomes the 48-bit c operand.
// PARAMETERS
//  CMD_DEPTH  4   command FIFO entries (power of 2, >=2)
//  RES_DEPTH  4   result FIFO entries (>=3 needed for 1 op/cycle throughput)
//  NW         18  narrow operand width (a, b, d)
//  WW         48  wide operand/result width (c, P)
// PORTS
//  clk          in   1    single clock, rising edge
//  rst_n        in   1    asynchronous active-low reset
//  cmd_valid    in   1    command present
//  cmd_ready    out  1    = command FIFO not full
//  cmd_op       in   2    0 ADD a+b, 1 SUB a-b, 2 ADDC c+a+cin, 3 XOR a^d
//  cmd_a        in   NW   operand a
//  cmd_b        in   NW   operand b
//  cmd_d        in   NW   operand d
//  cmd_c        in   WW   operand c (ignored when cmd_chain=1)
//  cmd_cin      in   1    carry-in for ADDC
//  cmd_chain    in   1    1: use last captured result as c (meaningful for op 2 only)
//  alu_a/b/d    out  NW   registered drives to ALU a/b/d
//  alu_c        out  WW   registered drive to ALU c
//  alu_carryin  out  1    registered drive to ALU carryin
//  alu_select   out  2    registered drive to ALU select
//  alu_p        in   WW   ALU registered output P
//  res_valid    out  1    = result FIFO not empty
//  res_ready    in   1    consumer accepts result
//  res_data     out  WW   head result
//  res_op       out  2    op code that produced res_data
// BEHAVIOUR
//  Reset (async, rst_n=0) clears FIFOs, pipeline valids v1/v2 and last_result.
//   - Outputs: all alu_* = 0, res_valid = 0, res_data = 0, res_op = 0; cmd_ready = 1 (FIFO empty).
//   - Commands presented while rst_n=0 are discarded.
//  Command accept: edge with cmd_valid && cmd_ready.
//   - No push when full, even if a pop occurs in the same cycle (no full-bypass).
//  Issue (edge E):
//   - Pop FIFO head, load alu_* regs, set v1; at E+1 the ALU latches P and v2 <= v1.
//   - At E+2, when v2=1: push {alu_p, op} into result FIFO; last_result <= alu_p.
//   - Otherwise v1, v2 <= 0.
//  Credit rule: issue only if (res_count + v1 + v2) < RES_DEPTH, where res_count counts after this edge's pop.
//   - The result FIFO can never overflow and results are never dropped.
//  Chain rule: a head command with cmd_chain=1 and op=2 issues only when v1=v2=0.
//   - It stalls otherwise; alu_c = last_result.
//   - cmd_chain is ignored for ops 0, 1 and 3.
//  Idle cycles: alu_* regs hold their last value; ALU output is ignored while v2=0.
//  Latency: accept at edge T -> earliest issue T+1 -> ALU latch T+2 -> capture T+3.
//   - res_valid is high in the cycle after T+3.
//  Throughput: 1 op/cycle with res_ready=1 and no chains; a chained op costs 2 bubble cycles.
//  Ordering: results leave in command order; res_data/res_op are stable while res_valid && !res_ready.
//  Arithmetic (performed by the ALU, relied on by the bench): ADD/SUB/XOR zero-extend to 48 b; all wrap mod 2^48.
//  Simultaneous result push and pop in one cycle is legal at any occupancy that the credit rule allows.
//  Reset mid-operation: in-flight and buffered results are lost, with no partial output.
// STRUCTURE
//  alu_pkg: OP_ADD=2'd0, OP_SUB=2'd1, OP_ADDC=2'd2, OP_XOR=2'd3; NW/WW defaults; cmd struct layout {op,a,b,d,c,cin,chain}.
//  Sub-module sync_fifo (WIDTH, DEPTH; async active-low reset; push/pop/full/empty/count).
//   - Instantiated twice: command FIFO and result FIFO.
//  Top level holds issue logic, v1/v2 pipeline, credit counter, last_result and the alu_* registers.
// TESTING
//  1 Reset, ADD a=5 b=3 -> res_data=48'd8, res_op=0, res_valid 3 cycles after accept.
//  2 Stream ADD 1+1, SUB 3-5, XOR a=0x3FFFF d=0x00FF0, ADDC c=100 a=7 cin=1; res_ready=1.
//     -> in order: 2, 48'hFFFF_FFFF_FFFE, 48'h3F00F, 108, on 4 consecutive cycles.
//  3 res_ready=0, push 10 ADDs -> issue halts after RES_DEPTH results, cmd_ready drops when CMD_DEPTH queued.
//     -> releasing res_ready drains all 10 in order, none lost or duplicated.
//  4 ADD 10+20, then ADDC chain a=1 cin=1 -> second result 48'd32; exactly 2 bubble cycles before chained issue.
//  5 ADDC c=48'hFFFF_FFFF_FFFF a=0 cin=1 -> res_data=0 (wrap).
//     ADDC c=0 a=18'h3FFFF cin=1 -> 48'h40000.
//  6 Assert rst_n=0 mid-stream (between clk edges) -> res_valid, alu_* go 0 immediately; cmd_ready=1.
//     -> after release, ADD 2+2 -> 4 with no stale results.

Source files
------------

// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the ALU issue stage: op encodings and default operand widths.
package alu_issue_ctrl_pkg;

  localparam int NW_DEF = 18;
  localparam int WW_DEF = 48;

  typedef enum logic [1:0] {
    OP_ADD  = 2'd0,
    OP_SUB  = 2'd1,
    OP_ADDC = 2'd2,
    OP_XOR  = 2'd3
  } op_e;

endpackage

// File: rtl/alu_issue_ctrl_sync_fifo.sv
// Single-clock FIFO with a combinational head read.
// The head is read combinationally so the issue logic can inspect it in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_PTR  = AW'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             push_ok, pop_ok;

  // Pushes are refused when full even if a pop happens on the same edge.
  assign full_o  = (count_q == DEPTH_CNT);
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
      unique case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue stage for a registered 4-op ALU: buffers commands, drives ALU inputs,
// tracks its one-cycle latency and captures results in order, with result chaining.
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int CMD_DEPTH = 4,
  parameter int RES_DEPTH = 4,
  parameter int NW        = NW_DEF,
  parameter int WW        = WW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [NW-1:0] cmd_a,
  input  logic [NW-1:0] cmd_b,
  input  logic [NW-1:0] cmd_d,
  input  logic [WW-1:0] cmd_c,
  input  logic          cmd_cin,
  input  logic          cmd_chain,
  output logic [NW-1:0] alu_a,
  output logic [NW-1:0] alu_b,
  output logic [NW-1:0] alu_d,
  output logic [WW-1:0] alu_c,
  output logic          alu_carryin,
  output logic [1:0]    alu_select,
  input  logic [WW-1:0] alu_p,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [WW-1:0] res_data,
  output logic [1:0]    res_op
);
  localparam int CMD_W = 2 + 3*NW + WW + 2;
  localparam int RES_W = WW + 2;
  localparam int CCW   = $clog2(CMD_DEPTH) + 1;
  localparam int RCW   = $clog2(RES_DEPTH) + 1;
  localparam int SUMW  = RCW + 1;

  logic [CMD_W-1:0] cmd_wdata, cmd_rdata;
  logic             cmd_full, cmd_empty;
  logic [CCW-1:0]   cmd_count_unused;
  logic [RES_W-1:0] res_wdata, res_rdata;
  logic             res_full, res_empty, res_push, res_pop;
  logic [RCW-1:0]   res_count;

  logic [1:0]       h_op;
  logic [NW-1:0]    h_a, h_b, h_d;
  logic [WW-1:0]    h_c;
  logic             h_cin, h_chain, h_is_chain;
  logic [SUMW-1:0]  credit_sum;
  logic             credit_ok, chain_block, issue;

  logic [NW-1:0]    alu_a_q, alu_a_d, alu_b_q, alu_b_d, alu_d_q, alu_d_d;
  logic [WW-1:0]    alu_c_q, alu_c_d, last_result_q, last_result_d;
  logic             alu_cin_q, alu_cin_d, v1_q, v1_d, v2_q, v2_d;
  logic [1:0]       alu_sel_q, alu_sel_d, op2_q, op2_d;

  assign cmd_wdata = {cmd_op, cmd_a, cmd_b, cmd_d, cmd_c, cmd_cin, cmd_chain};
  assign {h_op, h_a, h_b, h_d, h_c, h_cin, h_chain} = cmd_rdata;

  sync_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk(clk), .rst_n(rst_n), .push_i(cmd_valid), .pop_i(issue),
    .wdata_i(cmd_wdata), .rdata_o(cmd_rdata), .full_o(cmd_full),
    .empty_o(cmd_empty), .count_o(cmd_count_unused)
  );

  sync_fifo #(.WIDTH(RES_W), .DEPTH(RES_DEPTH)) u_res_fifo (
    .clk(clk), .rst_n(rst_n), .push_i(res_push), .pop_i(res_pop),
    .wdata_i(res_wdata), .rdata_o(res_rdata), .full_o(res_full),
    .empty_o(res_empty), .count_o(res_count)
  );

  assign cmd_ready = !cmd_full;
  assign res_pop   = res_ready && !res_empty;
  assign res_push  = v2_q && !res_full;
  assign res_wdata = {alu_p, op2_q};

  // Every in-flight op already owns a result slot, so the FIFO cannot overflow.
  assign credit_sum  = SUMW'(res_count) - SUMW'(res_pop) + SUMW'(v1_q) + SUMW'(v2_q);
  assign credit_ok   = credit_sum < SUMW'(RES_DEPTH);
  assign h_is_chain  = (h_op == OP_ADDC) && h_chain;
  assign chain_block = h_is_chain && (v1_q || v2_q);
  assign issue       = !cmd_empty && credit_ok && !chain_block;

  always_comb begin
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    alu_d_d       = alu_d_q;
    alu_c_d       = alu_c_q;
    alu_cin_d     = alu_cin_q;
    alu_sel_d     = alu_sel_q;
    v1_d          = issue;
    v2_d          = v1_q;
    op2_d         = alu_sel_q;
    last_result_d = v2_q ? alu_p : last_result_q;
    if (issue) begin
      alu_a_d   = h_a;
      alu_b_d   = h_b;
      alu_d_d   = h_d;
      alu_c_d   = h_is_chain ? last_result_q : h_c;
      alu_cin_d = h_cin;
      alu_sel_d = h_op;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_d_q       <= '0;
      alu_c_q       <= '0;
      alu_cin_q     <= 1'b0;
      alu_sel_q     <= '0;
      v1_q          <= 1'b0;
      v2_q          <= 1'b0;
      op2_q         <= '0;
      last_result_q <= '0;
    end else begin
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      alu_d_q       <= alu_d_d;
      alu_c_q       <= alu_c_d;
      alu_cin_q     <= alu_cin_d;
      alu_sel_q     <= alu_sel_d;
      v1_q          <= v1_d;
      v2_q          <= v2_d;
      op2_q         <= op2_d;
      last_result_q <= last_result_d;
    end
  end

  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_d       = alu_d_q;
  assign alu_c       = alu_c_q;
  assign alu_carryin = alu_cin_q;
  assign alu_select  = alu_sel_q;
  // FIFO storage is not reset, so mask the head while empty.
  assign res_valid   = !res_empty;
  assign res_data    = res_empty ? '0 : res_rdata[RES_W-1:2];
  assign res_op      = res_empty ? '0 : res_rdata[1:0];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural registered ALU model.
module tb_alu_issue_ctrl;
  import alu_issue_ctrl_pkg::*;

  localparam int NW = 18;
  localparam int WW = 48;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0, cmd_ready;
  logic [1:0]    cmd_op = '0;
  logic [NW-1:0] cmd_a = '0, cmd_b = '0, cmd_d = '0;
  logic [WW-1:0] cmd_c = '0;
  logic          cmd_cin = 1'b0, cmd_chain = 1'b0;
  logic [NW-1:0] alu_a, alu_b, alu_d;
  logic [WW-1:0] alu_c;
  logic          alu_carryin;
  logic [1:0]    alu_select;
  logic [WW-1:0] alu_p = '0;
  logic          res_valid, res_ready = 1'b0;
  logic [WW-1:0] res_data;
  logic [1:0]    res_op;

  int checks = 0;
  int errors = 0;
  int accepted = 0;
  int cyc = 0;

  typedef struct {
    logic [WW-1:0] data;
    logic [1:0]    op;
    int            cyc;
  } pop_t;
  pop_t popq[$];

  typedef struct {
    logic [1:0]    op;
    logic [NW-1:0] a, b, d;
    logic [WW-1:0] c;
    logic          cin, chain;
    logic [WW-1:0] exp;
  } vec_t;
  vec_t vecs[7];

  alu_issue_ctrl #(.CMD_DEPTH(4), .RES_DEPTH(4), .NW(NW), .WW(WW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_d(cmd_d), .cmd_c(cmd_c),
    .cmd_cin(cmd_cin), .cmd_chain(cmd_chain),
    .alu_a(alu_a), .alu_b(alu_b), .alu_d(alu_d), .alu_c(alu_c),
    .alu_carryin(alu_carryin), .alu_select(alu_select), .alu_p(alu_p),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_op(res_op)
  );

  always #5 clk = ~clk;

  // Registered ALU: P follows its inputs one clock later.
  always @(posedge clk) begin
    case (alu_select)
      OP_ADD:  alu_p <= {30'd0, alu_a} + {30'd0, alu_b};
      OP_SUB:  alu_p <= {30'd0, alu_a} - {30'd0, alu_b};
      OP_ADDC: alu_p <= alu_c + {30'd0, alu_a} + {47'd0, alu_carryin};
      default: alu_p <= {30'd0, alu_a ^ alu_d};
    endcase
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) popq.push_back('{res_data, res_op, cyc});
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end else begin
      $display("ok   %s = %h", name, act);
    end
  endtask

  // Call at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [1:0] op, input logic [NW-1:0] a, b, d,
                      input logic [WW-1:0] c, input logic cin, chain);
    int n = 0;
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_d = d; cmd_c = c;
    cmd_cin = cin; cmd_chain = chain; cmd_valid = 1'b1;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!cmd_ready) begin
      errors++;
      $display("FAIL send_accept actual=timeout required=accepted");
      cmd_valid = 1'b0;
    end else begin
      @(negedge clk);
      cmd_valid = 1'b0;
      accepted++;
    end
  endtask

  task automatic wait_pops(input int n, input int budget);
    int k = 0;
    while (popq.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
  endtask

  initial begin
    int lat;
    bit done;

    vecs[0] = '{OP_ADD,  18'd5,       18'd3,       18'd0,       48'd0,              1'b0, 1'b0, 48'd8};
    vecs[1] = '{OP_SUB,  18'd0,       18'd1,       18'd0,       48'd0,              1'b0, 1'b0, 48'hFFFF_FFFF_FFFF};
    vecs[2] = '{OP_XOR,  18'h3FFFF,   18'd7,       18'h00FF0,   48'd0,              1'b0, 1'b0, 48'h3F00F};
    vecs[3] = '{OP_ADDC, 18'd0,       18'd0,       18'd0,       48'hFFFF_FFFF_FFFF, 1'b1, 1'b0, 48'd0};
    vecs[4] = '{OP_ADDC, 18'h3FFFF,   18'd0,       18'd0,       48'd0,              1'b1, 1'b0, 48'h40000};
    vecs[5] = '{OP_ADD,  18'h3FFFF,   18'h3FFFF,   18'd0,       48'd0,              1'b0, 1'b1, 48'h7FFFE};
    vecs[6] = '{OP_ADDC, 18'd2,       18'd0,       18'd0,       48'h123,            1'b0, 1'b1, 48'h80000};

    // Reset with a command offered that must be discarded.
    cmd_valid = 1'b1; cmd_a = 18'd77;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", {47'd0, cmd_ready}, 48'd1);
    check("rst_res_valid", {47'd0, res_valid}, 48'd0);
    check("rst_res_data", res_data, 48'd0);
    check("rst_alu_c", alu_c, 48'd0);
    check("rst_alu_sel", {46'd0, alu_select}, 48'd0);
    cmd_valid = 1'b0; cmd_a = '0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_empty", {47'd0, res_valid}, 48'd0);

    // Isolated vectors: latency, value and op.
    for (int i = 0; i < 7; i++) begin
      send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].c, vecs[i].cin, vecs[i].chain);
      lat = 0;
      while (!res_valid && lat < 10) begin
        @(negedge clk);
        lat++;
      end
      check($sformatf("vec%0d_latency", i), 48'(lat), 48'd3);
      check($sformatf("vec%0d_data", i), res_data, vecs[i].exp);
      check($sformatf("vec%0d_op", i), {46'd0, res_op}, {46'd0, vecs[i].op});
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
    end
    @(negedge clk);
    check("table_drained", {47'd0, res_valid}, 48'd0);

    // Back-to-back stream, one result per cycle.
    popq.delete();
    res_ready = 1'b1;
    send(OP_ADD,  18'd1,     18'd1, 18'd0,     48'd0,   1'b0, 1'b0);
    send(OP_SUB,  18'd3,     18'd5, 18'd0,     48'd0,   1'b0, 1'b0);
    send(OP_XOR,  18'h3FFFF, 18'd0, 18'h00FF0, 48'd0,   1'b0, 1'b0);
    send(OP_ADDC, 18'd7,     18'd0, 18'd0,     48'd100, 1'b1, 1'b0);
    wait_pops(4, 30);
    check("stream_count", 48'(popq.size()), 48'd4);
    if (popq.size() == 4) begin
      check("stream0", popq[0].data, 48'd2);
      check("stream1", popq[1].data, 48'hFFFF_FFFF_FFFE);
      check("stream2", popq[2].data, 48'h3F00F);
      check("stream3", popq[3].data, 48'd108);
      check("stream3_op", {46'd0, popq[3].op}, 48'd2);
      check("stream_spacing", 48'(popq[3].cyc - popq[0].cyc), 48'd3);
    end

    // Backpressure: issue stops at RES_DEPTH, commands pile up to CMD_DEPTH.
    popq.delete();
    res_ready = 1'b0;
    accepted = 0;
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 10; i++)
          send(OP_ADD, 18'(i), 18'd100, 18'd0, 48'd0, 1'b0, 1'b0);
        done = 1'b1;
      end
    join_none
    repeat (30) @(negedge clk);
    check("bp_accepted", 48'(accepted), 48'd8);
    check("bp_cmd_ready", {47'd0, cmd_ready}, 48'd0);
    check("bp_alu_a_held", {30'd0, alu_a}, 48'd3);
    check("bp_head", res_data, 48'd100);
    @(negedge clk);
    check("bp_head_stable", res_data, 48'd100);
    res_ready = 1'b1;
    wait_pops(10, 100);
    for (int k = 0; k < 50 && !done; k++) @(negedge clk);
    repeat (5) @(negedge clk);
    check("bp_count", 48'(popq.size()), 48'd10);
    for (int i = 0; i < 10 && i < popq.size(); i++)
      check($sformatf("bp_order%0d", i), popq[i].data, 48'(i + 100));

    // Chained ADDC waits for the previous result: two bubble cycles.
    popq.delete();
    send(OP_ADD,  18'd10, 18'd20, 18'd0, 48'd0,   1'b0, 1'b0);
    send(OP_ADDC, 18'd1,  18'd0,  18'd0, 48'd999, 1'b1, 1'b1);
    wait_pops(2, 30);
    check("chain_count", 48'(popq.size()), 48'd2);
    if (popq.size() == 2) begin
      check("chain_first", popq[0].data, 48'd30);
      check("chain_second", popq[1].data, 48'd32);
      check("chain_gap", 48'(popq[1].cyc - popq[0].cyc), 48'd3);
    end

    // Asynchronous reset mid-stream.
    popq.delete();
    res_ready = 1'b0;
    send(OP_ADD, 18'd1, 18'd1, 18'd0, 48'd0, 1'b0, 1'b0);
    send(OP_ADD, 18'd5, 18'd5, 18'd0, 48'd0, 1'b0, 1'b0);
    send(OP_ADD, 18'd9, 18'd9, 18'd0, 48'd0, 1'b0, 1'b0);
    repeat (6) @(negedge clk);
    check("prerst_valid", {47'd0, res_valid}, 48'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_res_valid", {47'd0, res_valid}, 48'd0);
    check("arst_res_data", res_data, 48'd0);
    check("arst_alu_a", {30'd0, alu_a}, 48'd0);
    check("arst_cmd_ready", {47'd0, cmd_ready}, 48'd1);
    @(negedge clk);
    rst_n = 1'b1;
    res_ready = 1'b1;
    @(negedge clk);
    send(OP_ADD, 18'd2, 18'd2, 18'd0, 48'd0, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    check("postrst_count", 48'(popq.size()), 48'd1);
    if (popq.size() >= 1) check("postrst_data", popq[0].data, 48'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
